// File: rtl/bcd_display_scanner_pkg.sv
// Shared seven-segment constants, segment bit order, converter states.
// Segments are active low, packed as {a,b,c,d,e,f,g} (bit6 = a).
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = SEG_BLANK & ~(7'(1) << SEG_G);

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } cv_state_e;

  function automatic logic [6:0] seg7_dec(input logic [3:0] n);
    if (n > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[n];
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Valid/ready input bus for the display scanner.
// master drives in_valid/in_value, slave returns in_ready.
interface bcd_display_scanner_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;

  modport master (
    output in_valid,
    output in_value,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_value,
    output in_ready
  );
endinterface

// File: rtl/bcd_display_scanner_dd.sv
// bcd_dd_seq: sequential double-dabble, one bit per clock.
// Ports: clk, rst_n, in_valid/in_ready/in_value, done pulse, bcd (latched).
module bcd_dd_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NB    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic            done,
  output logic [4*NB-1:0] bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  cv_state_e       st;
  logic [WIDTH-1:0] bin;
  logic [4*NB-1:0] acc;
  logic [4*NB-1:0] adj;
  logic [CW-1:0]   cnt;

  for (genvar g = 0; g < NB; g++) begin : g_adj
    assign adj[4*g +: 4] = (acc[4*g +: 4] >= 4'd5) ?
                           acc[4*g +: 4] + 4'd3 :
                           acc[4*g +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      in_ready <= 1'b1;
      done     <= 1'b0;
      bin      <= '0;
      acc      <= '0;
      cnt      <= '0;
      bcd      <= '0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            bin      <= in_value;
            acc      <= '0;
            cnt      <= CW'(WIDTH);
            st       <= SHIFT;
            in_ready <= 1'b0;
          end
        end
        SHIFT: begin
          {acc, bin} <= {adj, bin} << 1;
          cnt        <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            st       <= DONE;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          bcd  <= acc;
          done <= 1'b1;
          // back-to-back accept keeps the converter busy
          if (in_valid) begin
            bin      <= in_value;
            acc      <= '0;
            cnt      <= CW'(WIDTH);
            st       <= SHIFT;
            in_ready <= 1'b0;
          end else begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD converter driving a multiplexed common-anode display.
// Ports: clk, rst_n, bus (valid/ready/value), blank_lz, done, ovf, bcd_out, seg_n, an_n.
module bcd_display_scanner
  import seg7_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_display_scanner_if.slave bus,
  input  logic                blank_lz,
  output logic                done,
  output logic                ovf,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [6:0]          seg_n,
  output logic [DIGITS-1:0]   an_n
);

  // floor(WIDTH*log10(2))+1 digits hold any WIDTH-bit value
  localparam int NB0 = (WIDTH * 30103) / 100000 + 1;
  localparam int NB  = (NB0 < DIGITS) ? DIGITS : NB0;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW  = $clog2(REFRESH_DIV);

  logic [4*NB-1:0] res;

  bcd_dd_seq #(
    .WIDTH (WIDTH),
    .NB    (NB)
  ) u_dd (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_value (bus.in_value),
    .done     (done),
    .bcd      (res)
  );

  assign bcd_out = res[4*DIGITS-1:0];

  if (NB > DIGITS) begin : g_ovf
    assign ovf = |res[4*NB-1:4*DIGITS];
  end else begin : g_novf
    assign ovf = 1'b0;
  end

  logic [PW-1:0]       pcnt;
  logic [IW-1:0]       idx;
  logic                lit;
  logic                wrap;
  logic [4*DIGITS-1:0] hi;
  logic                blank;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  assign wrap = (pcnt == PW'(REFRESH_DIV - 1));

  // hi holds the current digit and all digits above it
  always_comb begin
    hi    = bcd_out >> {idx, 2'b00};
    blank = blank_lz & (idx != '0) & (hi == '0);
    an_d  = ~(DIGITS'(1) << idx);
    if (ovf)
      seg_d = SEG_DASH;
    else if (blank)
      seg_d = SEG_BLANK;
    else
      seg_d = seg7_dec(hi[3:0]);
  end

  // lit holds the display dark until the first prescaler wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt  <= '0;
      idx   <= '0;
      lit   <= 1'b0;
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else begin
      pcnt <= wrap ? '0 : pcnt + PW'(1);
      if (wrap) begin
        lit <= 1'b1;
        if (lit)
          idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end
      an_n  <= lit ? an_d : '1;
      seg_n <= lit ? seg_d : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (WIDTH=16, DIGITS=4, REFRESH_DIV=4).
// Expected values come from a decimal-arithmetic model of the display.
module tb_bcd_display_scanner;

  localparam int W = 16;
  localparam int D = 4;
  localparam int R = 4;

  localparam logic [6:0] SEGT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blank_lz = 1'b0;
  logic         done;
  logic         ovf;
  logic [15:0]  bcd_out;
  logic [6:0]   seg_n;
  logic [3:0]   an_n;

  bcd_display_scanner_if #(.WIDTH(W)) bus ();

  bcd_display_scanner #(
    .WIDTH       (W),
    .DIGITS      (D),
    .REFRESH_DIV (R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .blank_lz (blank_lz),
    .done     (done),
    .ovf      (ovf),
    .bcd_out  (bcd_out),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned lastv = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_digit(input int unsigned v, input int i);
    int unsigned p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] m_bcd(input int unsigned v);
    logic [15:0] r = '0;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'(m_digit(v, i));
    return r;
  endfunction

  function automatic logic [6:0] m_seg(input int unsigned v, input logic blz,
                                       input int i);
    int unsigned p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (v >= 10000) return 7'b1111110;
    if (blz && i > 0 && (v / p) == 0) return 7'b1111111;
    return SEGT[m_digit(v, i)];
  endfunction

  task automatic conv(input int unsigned v);
    int cyc;
    chk("ready_pre", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_value = 16'(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 17);
    chk("bcd_out", bcd_out, m_bcd(v));
    chk("ovf", ovf, v >= 10000);
    lastv = v;
  endtask

  task automatic scan(input int unsigned v, input logic blz);
    logic [3:0] prev;
    logic [3:0] ea;
    int k;
    repeat (2) @(negedge clk);
    prev = an_n;
    @(negedge clk);
    k = 0;
    while (!(an_n == 4'b1110 && prev != 4'b1110) && k < 40) begin
      prev = an_n;
      @(negedge clk);
      k++;
    end
    chk("scan_sync", k < 40, 1);
    for (int d = 0; d < D; d++) begin
      ea = ~(4'b0001 << d);
      for (int c = 0; c < R; c++) begin
        chk($sformatf("an_dig%0d", d), an_n, ea);
        chk($sformatf("seg_dig%0d", d), seg_n, m_seg(v, blz, d));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int k;
    int nr;
    int cyc;
    int nd;
    int unsigned nv;
    int unsigned e;
    int unsigned q[$];
    logic [15:0] hold;

    bus.in_valid = 1'b0;
    bus.in_value = '0;

    repeat (10) @(negedge clk);
    chk("rst_an", an_n, 4'hF);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);

    rst_n = 1'b1;
    k = 0;
    while (an_n == 4'hF && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_lit", k, R + 1);
    chk("first_an", an_n, 4'b1110);
    chk("first_seg", seg_n, 7'b0000001);

    conv(1234);
    scan(1234, 1'b0);

    bus.in_valid = 1'b1;
    bus.in_value = 16'd9999;
    @(negedge clk);
    bus.in_value = 16'd10000;
    nr = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c < 16 && bus.in_ready) nr++;
    end
    chk("b2b_busy", nr, 0);
    chk("b2b_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_done1", done, 1);
    chk("b2b_bcd1", bcd_out, m_bcd(9999));
    chk("b2b_ovf1", ovf, 0);
    chk("b2b_reacc", bus.in_ready, 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 40);
    chk("b2b_lat2", cyc, 17);
    chk("b2b_bcd2", bcd_out, m_bcd(10000));
    chk("b2b_ovf2", ovf, 1);
    lastv = 10000;
    scan(10000, 1'b0);

    blank_lz = 1'b1;
    conv(7);
    scan(7, 1'b1);
    blank_lz = 1'b0;
    scan(7, 1'b0);

    repeat (6) begin
      nv = $urandom_range(0, 65535);
      blank_lz = 1'($urandom_range(0, 1));
      conv(nv);
      scan(nv, blank_lz);
    end

    hold = m_bcd(lastv);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("cv_spurious", 1, 0);
        end else begin
          e = q.pop_front();
          chk("cv_bcd", bcd_out, m_bcd(e));
          chk("cv_ovf", ovf, e >= 10000);
          hold = m_bcd(e);
        end
      end else begin
        chk("cv_hold", bcd_out, hold);
      end
      nv = $urandom_range(0, 65535);
      bus.in_value = 16'(nv);
      if (bus.in_ready) q.push_back(nv);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      if (done) begin
        e = q.pop_front();
        chk("cv_bcd", bcd_out, m_bcd(e));
        chk("cv_ovf", ovf, e >= 10000);
      end
      @(negedge clk);
    end
    chk("cv_drain", q.size(), 0);

    bus.in_valid = 1'b1;
    bus.in_value = 16'd999;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_an", an_n, 4'hF);
    chk("mid_seg", seg_n, 7'h7F);
    chk("mid_bcd", bcd_out, 0);
    chk("mid_ovf", ovf, 0);
    chk("mid_ready", bus.in_ready, 1);
    chk("mid_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_nodone", nd, 0);
    conv(42);
    chk("mid_42", bcd_out, 16'h0042);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
